// File: rtl/input_bank.sv
// input_bank: memory-mapped switch/button input block at 0x7800-0x780F.
// Registers: SW (RO), BTN debounced level (RO), PRESS (W1C), IRQ_MASK (RW [3:0]).

// Per-button debouncer: toggles its level after DEBOUNCE_CYCLES stable cycles.
module input_bank_deb #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic sync_i,
  output logic db_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_q, db_d;

  // Count while the input disagrees with the level; flip and restart at the limit.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (sync_i != db_q) begin
      if (cnt_q == CNT_MAX) db_d  = ~db_q;
      else                  cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter and debounced level state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  assign db_o = db_q;
endmodule

module input_bank #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_lsu_addr,
  input  logic        i_lsu_wren,
  input  logic        i_lsu_read,
  input  logic [31:0] i_st_data,
  input  logic [2:0]  funct3,
  input  logic        input_buf_en,
  input  logic [31:0] i_io_sw,
  input  logic [3:0]  i_io_btn,
  output logic [31:0] o_ld_data,
  output logic        o_btn_irq
);
  localparam int NUM_BTN = 4;

  logic [31:0]        sw_s1_q, sw_s2_q;
  logic [NUM_BTN-1:0] btn_s1_q, btn_s2_q;
  logic [NUM_BTN-1:0] db_lvl, db_prev_q;
  logic [NUM_BTN-1:0] press_q, press_d, mask_q, mask_d;
  logic               irq_q, irq_d;
  logic               lo_we;
  logic [1:0]         boff;
  logic [31:0]        rd_word, ld_d;
  logic [7:0]         rd_byte;

  assign boff = i_lsu_addr[1:0];

  // Two-flop synchronizers; buttons inverted so pressed reads as 1.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      btn_s1_q <= '0;
      btn_s2_q <= '0;
    end else begin
      sw_s1_q  <= i_io_sw;
      sw_s2_q  <= sw_s1_q;
      btn_s1_q <= ~i_io_btn;
      btn_s2_q <= btn_s1_q;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_BTN; g++) begin : g_deb
      input_bank_deb #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .sync_i  (btn_s2_q[g]),
        .db_o    (db_lvl[g])
      );
    end
  endgenerate

  // Only byte lane 0 holds register bits [3:0], and every store size puts
  // i_st_data[3:0] there, so the size code only decides whether lane 0 is hit.
  always_comb begin
    lo_we = 1'b0;
    case (funct3)
      3'b000:         lo_we = (boff == 2'd0);
      3'b001, 3'b010: lo_we = 1'b1;
      default:        lo_we = 1'b0;
    endcase
  end

  // PRESS: W1C clear first, then rising-edge set so a simultaneous set wins.
  always_comb begin
    press_d = press_q;
    mask_d  = mask_q;
    if (input_buf_en && i_lsu_wren && lo_we) begin
      if (i_lsu_addr[3:2] == 2'd2) press_d = press_q & ~i_st_data[3:0];
      if (i_lsu_addr[3:2] == 2'd3) mask_d  = i_st_data[3:0];
    end
    press_d = press_d | (db_lvl & ~db_prev_q);
    irq_d   = |(press_q & mask_q);
  end

  // Register state: edge-detect history, flags, mask and irq.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      db_prev_q <= '0;
      press_q   <= '0;
      mask_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      db_prev_q <= db_lvl;
      press_q   <= press_d;
      mask_q    <= mask_d;
      irq_q     <= irq_d;
    end
  end

  // Load path: pick register, then format per size/sign code.
  always_comb begin
    case (i_lsu_addr[3:2])
      2'd0:    rd_word = sw_s2_q;
      2'd1:    rd_word = {28'b0, db_lvl};
      2'd2:    rd_word = {28'b0, press_q};
      default: rd_word = {28'b0, mask_q};
    endcase
    rd_byte = rd_word[8*boff +: 8];
    case (funct3)
      3'b000:  ld_d = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  ld_d = {{16{rd_word[15]}}, rd_word[15:0]};
      3'b010:  ld_d = rd_word;
      3'b100:  ld_d = {24'b0, rd_byte};
      3'b101:  ld_d = {16'b0, rd_word[15:0]};
      default: ld_d = '0;
    endcase
    o_ld_data = (input_buf_en && i_lsu_read) ? ld_d : 32'b0;
  end

  assign o_btn_irq = irq_q;

  logic unused_bits;
  assign unused_bits = ^{i_lsu_addr[31:4], i_st_data[31:4]};
endmodule

// File: tb/tb_input_bank.sv
// Directed bench for input_bank with DEBOUNCE_CYCLES = 8: stimulus pushes
// expectations into a queue, a negedge monitor pops and compares them.
module tb_input_bank;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr, st_data, io_sw, ld_data;
  logic        wren, rd;
  logic [2:0]  f3;
  logic        buf_en;
  logic [3:0]  io_btn;
  logic        irq;

  typedef struct {
    string       name;
    bit          is_irq;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   nvec = 0;
  int   nmis = 0;

  input_bank #(.DEBOUNCE_CYCLES(8)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_lsu_addr   (addr),
    .i_lsu_wren   (wren),
    .i_lsu_read   (rd),
    .i_st_data    (st_data),
    .funct3       (f3),
    .input_buf_en (buf_en),
    .i_io_sw      (io_sw),
    .i_io_btn     (io_btn),
    .o_ld_data    (ld_data),
    .o_btn_irq    (irq)
  );

  always #5 clk = ~clk;

  // Monitor: compare every pending expectation against DUT outputs mid-cycle.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = sb_q.pop_front();
      act = e.is_irq ? {31'b0, irq} : ld_data;
      nvec++;
      if (act !== e.exp) begin
        nmis++;
        $display("FAIL %s: got %h want %h", e.name, act, e.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string n, input bit is_irq, input logic [31:0] e);
    exp_t x;
    x.name = n; x.is_irq = is_irq; x.exp = e;
    sb_q.push_back(x);
  endtask

  // Present a load for one cycle and expect a given o_ld_data.
  task automatic ld(input string n, input logic [31:0] a, input logic [2:0] c,
                    input logic [31:0] e);
    buf_en = 1'b1; rd = 1'b1; addr = a; f3 = c;
    push(n, 1'b0, e);
    tick();
    rd = 1'b0;
  endtask

  task automatic st(input logic [31:0] a, input logic [2:0] c, input logic [31:0] d);
    buf_en = 1'b1; wren = 1'b1; addr = a; f3 = c; st_data = d;
    tick();
    wren = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; addr = 32'h7800; wren = 0; rd = 0; st_data = 0; f3 = 3'b010;
    buf_en = 1'b1; io_sw = 32'hA5A5_0F0F; io_btn = 4'hF;
    #2;
    push("rst_irq", 1'b1, 32'h0);
    rd = 1'b1; addr = 32'h7800;
    push("rst_sw", 1'b0, 32'h0);
    @(negedge clk); #1;
    rd = 1'b0;
    tick();
    rst_n = 1'b1;
    // SW path: two-cycle synchronizer then formatted loads
    tick(); tick();
    ld("lw_sw",   32'h7800, 3'b010, 32'hA5A5_0F0F);
    ld("lb_sw1",  32'h7801, 3'b000, 32'h0000_000F);
    ld("lbu_sw3", 32'h7803, 3'b100, 32'h0000_00A5);
    ld("lb_sw3",  32'h7803, 3'b000, 32'hFFFF_FFA5);
    ld("lhu_sw",  32'h7800, 3'b101, 32'h0000_0F0F);
    ld("bad_f3",  32'h7800, 3'b011, 32'h0);
    st(32'h7800, 3'b010, 32'h0);
    ld("sw_ro",   32'h7800, 3'b010, 32'hA5A5_0F0F);

    // btn[0] press: BTN after 2+8 edges, PRESS one edge later
    io_btn[0] = 1'b0;
    repeat (9) tick();
    ld("btn0_early", 32'h7804, 3'b010, 32'h0);
    ld("btn0_lvl",   32'h7804, 3'b010, 32'h1);
    ld("press0",     32'h7808, 3'b010, 32'h1);
    // 5-cycle glitch on btn[1] is rejected
    io_btn[1] = 1'b0; repeat (5) tick(); io_btn[1] = 1'b1;
    repeat (15) tick();
    ld("glitch_btn",   32'h7804, 3'b010, 32'h1);
    ld("glitch_press", 32'h7808, 3'b010, 32'h1);
    io_btn[0] = 1'b1; repeat (12) tick();
    ld("rel_btn",   32'h7804, 3'b010, 32'h0);
    ld("rel_press", 32'h7808, 3'b010, 32'h1);

    // W1C with sw and sb lanes
    io_btn[2] = 1'b0; repeat (12) tick(); io_btn[2] = 1'b1; repeat (12) tick();
    ld("press_5", 32'h7808, 3'b010, 32'h5);
    st(32'h7808, 3'b010, 32'h1);
    ld("w1c_sw", 32'h7808, 3'b010, 32'h4);
    st(32'h7809, 3'b000, 32'h04);
    ld("sb_off1", 32'h7808, 3'b010, 32'h4);
    st(32'h7808, 3'b000, 32'h04);
    ld("w1c_sb", 32'h7808, 3'b010, 32'h0);

    // Set wins over a same-cycle clear
    io_btn[2] = 1'b0; repeat (10) tick();
    st(32'h7808, 3'b010, 32'h4);
    ld("set_wins", 32'h7808, 3'b010, 32'h4);
    st(32'h7808, 3'b010, 32'h4);
    io_btn[2] = 1'b1; repeat (12) tick();
    ld("press_clr", 32'h7808, 3'b010, 32'h0);

    // IRQ mask and registered irq timing
    st(32'h780C, 3'b010, 32'hFFFF_FFF2);
    ld("mask_rd", 32'h780C, 3'b010, 32'h2);
    st(32'h780C, 3'b011, 32'hF);
    ld("mask_bad_f3", 32'h780C, 3'b010, 32'h2);
    io_btn[1] = 1'b0; repeat (10) tick();
    push("irq_pre", 1'b1, 32'h0); tick();
    push("irq_flag_edge", 1'b1, 32'h0);
    ld("press1", 32'h7808, 3'b010, 32'h2);
    push("irq_up", 1'b1, 32'h1);
    st(32'h7808, 3'b001, 32'h2);
    push("irq_hold", 1'b1, 32'h1); tick();
    push("irq_down", 1'b1, 32'h0); tick();
    io_btn[1] = 1'b1; repeat (12) tick();

    // Async reset mid-debounce
    st(32'h780C, 3'b010, 32'hF);
    io_btn[0] = 1'b0; repeat (12) tick();
    push("irq_before_rst", 1'b1, 32'h1);
    io_btn[3] = 1'b0; repeat (5) tick();
    rst_n = 1'b0;
    buf_en = 1'b1; rd = 1'b1; addr = 32'h7800; f3 = 3'b010;
    push("rst_async_sw", 1'b0, 32'h0);
    push("rst_async_irq", 1'b1, 32'h0);
    tick(); rd = 1'b0;
    ld("rst_btn",   32'h7804, 3'b010, 32'h0);
    ld("rst_press", 32'h7808, 3'b010, 32'h0);
    ld("rst_mask",  32'h780C, 3'b010, 32'h0);
    rst_n = 1'b1;
    buf_en = 1'b0; rd = 1'b1; addr = 32'h7800;
    push("buf_en_off", 1'b0, 32'h0);
    tick(); rd = 1'b0;
    repeat (9) tick();
    ld("post_rst_early", 32'h7808, 3'b010, 32'h0);
    ld("post_rst_press", 32'h7808, 3'b010, 32'h9);
    @(negedge clk); #1;
    if (sb_q.size() != 0) begin
      nmis++;
      $display("FAIL drain: got %0d pending want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/input_bank.md
INPUT_BANK -- requirements
Module: input_bank

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, giving the number of consecutive stable synchronized cycles needed to accept a button change (minimum 2).
REQ-002 The block SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port i_lsu_addr, input, 32 bits: LSU byte address; bits [3:2] select the register and bits [1:0] give the byte offset.
REQ-005 The block SHALL have port i_lsu_wren, input, 1 bit: store strobe.
REQ-006 The block SHALL have port i_lsu_read, input, 1 bit: load strobe.
REQ-007 The block SHALL have port i_st_data, input, 32 bits: store data.
REQ-008 The block SHALL have port funct3, input, 3 bits: RISC-V load/store size and sign code.
REQ-009 The block SHALL have port input_buf_en, input, 1 bit: decoded region select for 0x7800-0x780F.
REQ-010 The block SHALL have port i_io_sw, input, 32 bits: raw asynchronous switches.
REQ-011 The block SHALL have port i_io_btn, input, 4 bits: raw asynchronous push-buttons, active-low.
REQ-012 The block SHALL have port o_ld_data, output, 32 bits: formatted load data.
REQ-013 The block SHALL have port o_btn_irq, output, 1 bit: high while any unmasked press flag is set.

Function
REQ-014 The register map SHALL be: offset 0x0 SW (read-only), 0x4 BTN level (read-only), 0x8 PRESS flags (write-1-to-clear), 0xC IRQ_MASK (read/write, bits [3:0]); unused bits read 0.
REQ-015 i_io_sw and the inverted i_io_btn SHALL each pass through a 2-flop synchronizer; SW SHALL equal the second flop, giving 2-cycle latency from the raw input.
REQ-016 Each button SHALL have its own counter: clear when its synchronized value equals its debounced value; otherwise increment; when the count reaches DEBOUNCE_CYCLES-1, the debounced value SHALL toggle and the counter clear in the same cycle.
REQ-017 Any glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL NOT change the debounced value.
REQ-018 BTN[3:0] SHALL equal the debounced levels, active-high (pressed = 1).
REQ-019 A 0-to-1 debounced transition SHALL set the matching PRESS bit on the next edge; a release SHALL NOT set or clear it.
REQ-020 A store to PRESS with input_buf_en & i_lsu_wren SHALL clear every bit where the written value has a 1, after the value is placed in byte/half/word lanes per funct3 and byte offset.
REQ-021 If a set and a clear hit the same PRESS bit in the same cycle, the set SHALL win.
REQ-022 Stores to IRQ_MASK SHALL update the addressed lanes per funct3: sb writes one byte, sh writes [15:0], sw writes the whole word; other funct3 values SHALL be ignored.
REQ-023 Stores to SW or BTN SHALL be ignored.
REQ-024 o_btn_irq SHALL be registered as |(PRESS & IRQ_MASK[3:0]), so it rises one cycle after the flag sets.
REQ-025 o_ld_data SHALL be combinational from the selected register when input_buf_en & i_lsu_read, and 0 otherwise.
REQ-026 Load formatting SHALL follow funct3: lb/lbu give the sign- or zero-extended byte at the byte offset; lh/lhu give the extended [15:0]; lw gives the full word; other codes give 0.
REQ-027 Reads SHALL have no side effects.

Reset
REQ-028 While i_rst_n = 0, all of the following SHALL be 0 immediately, independent of i_clk: synchronizer flops, counters, debounced levels, PRESS, IRQ_MASK and o_btn_irq.
REQ-029 Reset deassertion during a button press SHALL produce a PRESS set only after a full debounce from the reset state.

Verification (bench sets DEBOUNCE_CYCLES = 8)
REQ-030 Scenario: i_io_sw = 0xA5A5_0F0F; lw at 0x7800 on cycle 3 -> o_ld_data = 0xA5A5_0F0F; lb at 0x7801 -> 0x0000_000F; lbu at 0x7803 -> 0x0000_00A5.
REQ-031 Scenario: i_io_btn[0] held low for 20 cycles -> BTN = 0x1 and PRESS = 0x1 within 2+8+1 cycles; a 5-cycle low pulse on btn[1] -> BTN and PRESS unchanged.
REQ-032 Scenario: PRESS = 0x5; sw 0x1 to 0x7808 -> PRESS = 0x4; sb 0x04 to 0x7808 -> PRESS = 0x0.
REQ-033 Scenario: PRESS bit 2 clear-store in the same cycle as a new btn[2] press -> PRESS[2] = 1.
REQ-034 Scenario: IRQ_MASK = 0x2 with btn[1] pressed -> o_btn_irq = 1 one cycle after PRESS[1] sets; clearing PRESS[1] -> o_btn_irq = 0 next cycle.
REQ-035 Scenario: i_rst_n pulsed low mid-debounce with IRQ_MASK = 0xF -> all registers read 0 and o_btn_irq = 0 with no clock edge; input_buf_en = 0 load -> o_ld_data = 0.
